// File: rtl/ahb_multi_change_writer.sv
// AHB-Lite write master that mirrors NUM_CH input fields into word registers of a slave,
// writing each changed field to its own address and optionally a commit flag after each batch.
module ahb_multi_change_writer #(
  parameter int          NUM_CH       = 2,
  parameter int          CH_W         = 8,
  parameter logic [31:0] BASE_ADDR    = 32'hC000_0000,
  parameter int          ADDR_STRIDE  = 4,
  parameter bit          DONE_EN      = 1'b1,
  parameter logic [31:0] DONE_ADDR    = 32'hC000_0040,
  parameter logic [31:0] DONE_VAL     = 32'h0000_0001,
  parameter bit          INIT_REFRESH = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH*CH_W-1:0] ch_data_i,
  input  logic                   refresh_i,
  output logic [31:0]            ahb_m_haddr_o,
  output logic                   ahb_m_hwrite_o,
  output logic [2:0]             ahb_m_hsize_o,
  output logic [2:0]             ahb_m_hburst_o,
  output logic [3:0]             ahb_m_hprot_o,
  output logic [1:0]             ahb_m_htrans_o,
  output logic                   ahb_m_hmastlock_o,
  output logic [31:0]            ahb_m_hwdata_o,
  input  logic                   ahb_m_hready_i,
  input  logic                   ahb_m_hresp_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [15:0]            wr_count_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic [CH_W-1:0]   shadow [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic              done_pend;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_done;
  logic [31:0]       haddr_q;
  logic [31:0]       hwdata_q;
  logic              err_q;
  logic [15:0]       wr_count_q;

  logic [NUM_CH-1:0] change_mask;
  logic [NUM_CH-1:0] clr_mask;
  logic [NUM_CH-1:0] pending_nxt;
  logic              done_nxt;
  logic              addr_accept;
  logic              data_done;
  logic              sel_any;
  logic [IDX_W-1:0]  sel_idx;
  logic [31:0]       chan_addr;

  // Pending view for next-transfer selection: clear of the accepted channel, then new
  // changes and refresh on top, so a same-cycle change always wins.
  always_comb begin
    change_mask = '0;
    clr_mask    = '0;
    addr_accept = (state == ADDR) && ahb_m_hready_i;
    data_done   = (state == DATA) && ahb_m_hready_i;
    for (int k = 0; k < NUM_CH; k++) begin
      change_mask[k] = (ch_data_i[k*CH_W +: CH_W] != shadow[k]);
      clr_mask[k]    = addr_accept && !cur_done && (cur_idx == IDX_W'(k));
    end
    pending_nxt = (pending & ~clr_mask) | change_mask | {NUM_CH{refresh_i}};

    done_nxt = done_pend;
    if (addr_accept && !cur_done) done_nxt = DONE_EN;
    if (data_done && cur_done)    done_nxt = 1'b0;

    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending_nxt[k]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(k);
      end
    end
    chan_addr = BASE_ADDR + 32'(sel_idx) * 32'(ADDR_STRIDE);
  end

  // Single sequential block: change tracking plus the IDLE/ADDR/DATA transfer sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      haddr_q    <= '0;
      hwdata_q   <= '0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
      pending    <= INIT_REFRESH ? '1 : '0;
      done_pend  <= 1'b0;
      cur_idx    <= '0;
      cur_done   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= ch_data_i[k*CH_W +: CH_W];
    end else begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= ch_data_i[k*CH_W +: CH_W];
      pending   <= pending_nxt;
      done_pend <= done_nxt;

      case (state)
        IDLE: begin
          if (sel_any) begin
            state    <= ADDR;
            cur_idx  <= sel_idx;
            cur_done <= 1'b0;
            haddr_q  <= chan_addr;
          end else if (done_nxt) begin
            state    <= ADDR;
            cur_done <= 1'b1;
            haddr_q  <= DONE_ADDR;
          end
        end
        ADDR: begin
          if (ahb_m_hready_i) begin
            hwdata_q <= cur_done ? DONE_VAL : 32'(shadow[cur_idx]);
            state    <= DATA;
          end
        end
        DATA: begin
          if (ahb_m_hresp_i) err_q <= 1'b1;
          if (ahb_m_hready_i) begin
            if (!ahb_m_hresp_i) wr_count_q <= wr_count_q + 16'd1;
            if (sel_any) begin
              state    <= ADDR;
              cur_idx  <= sel_idx;
              cur_done <= 1'b0;
              haddr_q  <= chan_addr;
            end else if (done_nxt) begin
              state    <= ADDR;
              cur_done <= 1'b1;
              haddr_q  <= DONE_ADDR;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ahb_m_haddr_o     = haddr_q;
  assign ahb_m_hwrite_o    = (state == ADDR);
  assign ahb_m_hsize_o     = 3'b010;
  assign ahb_m_hburst_o    = 3'b000;
  assign ahb_m_hprot_o     = 4'b0000;
  assign ahb_m_htrans_o    = (state == ADDR) ? 2'b10 : 2'b00;
  assign ahb_m_hmastlock_o = 1'b0;
  assign ahb_m_hwdata_o    = hwdata_q;
  assign busy_o            = (state != IDLE);
  assign err_o             = err_q;
  assign wr_count_o        = wr_count_q;

endmodule

// File: tb/tb_ahb_multi_change_writer.sv
// Directed bench: a small AHB slave with programmable wait states and error injection
// logs completed writes, which are compared against hand-written expected write lists.
module tb_ahb_multi_change_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ch_data;
  logic        refresh;
  logic [31:0] haddr, hwdata;
  logic        hwrite, hmastlock, hready, hresp, busy, err;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [15:0] wr_count;

  logic        reset4;
  logic [31:0] ch_data4;
  logic        refresh4;
  logic [31:0] haddr4, hwdata4;
  logic        hwrite4, hmastlock4, busy4, err4;
  logic [2:0]  hsize4, hburst4;
  logic [3:0]  hprot4;
  logic [1:0]  htrans4;
  logic [15:0] wr_count4;
  logic        hready4 = 1'b1;
  logic        hresp4  = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] log_a[$], log_d[$], exp_a[$], exp_d[$];
  logic        log_ok[$], exp_ok[$];

  int          addr_wait = 0, data_wait = 0;
  logic        err_arm = 1'b0;
  logic [31:0] err_addr = 32'hC000_0000;

  always #5 clk = ~clk;

  ahb_multi_change_writer dut (
    .clk(clk), .reset(reset), .ch_data_i(ch_data), .refresh_i(refresh),
    .ahb_m_haddr_o(haddr), .ahb_m_hwrite_o(hwrite), .ahb_m_hsize_o(hsize),
    .ahb_m_hburst_o(hburst), .ahb_m_hprot_o(hprot), .ahb_m_htrans_o(htrans),
    .ahb_m_hmastlock_o(hmastlock), .ahb_m_hwdata_o(hwdata),
    .ahb_m_hready_i(hready), .ahb_m_hresp_i(hresp),
    .busy_o(busy), .err_o(err), .wr_count_o(wr_count)
  );

  ahb_multi_change_writer #(.NUM_CH(4), .INIT_REFRESH(1'b0)) dut4 (
    .clk(clk), .reset(reset4), .ch_data_i(ch_data4), .refresh_i(refresh4),
    .ahb_m_haddr_o(haddr4), .ahb_m_hwrite_o(hwrite4), .ahb_m_hsize_o(hsize4),
    .ahb_m_hburst_o(hburst4), .ahb_m_hprot_o(hprot4), .ahb_m_htrans_o(htrans4),
    .ahb_m_hmastlock_o(hmastlock4), .ahb_m_hwdata_o(hwdata4),
    .ahb_m_hready_i(hready4), .ahb_m_hresp_i(hresp4),
    .busy_o(busy4), .err_o(err4), .wr_count_o(wr_count4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ch);
    @(posedge clk);
    #1;
    ch_data = ch;
  endtask

  task automatic expectWrite(input logic [31:0] a, input logic [31:0] d, input logic ok);
    exp_a.push_back(a);
    exp_d.push_back(d);
    exp_ok.push_back(ok);
  endtask

  task automatic compareLog();
    int n;
    checkOutput("num_writes", 32'(log_a.size()), 32'(exp_a.size()));
    n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("wr%0d_addr", i), log_a[i], exp_a[i]);
      checkOutput($sformatf("wr%0d_data", i), log_d[i], exp_d[i]);
      checkOutput($sformatf("wr%0d_okay", i), 32'(log_ok[i]), 32'(exp_ok[i]));
    end
    log_a.delete(); log_d.delete(); log_ok.delete();
    exp_a.delete(); exp_d.delete(); exp_ok.delete();
  endtask

  task automatic waitIdle(input bit four);
    int n = 0;
    repeat (2) @(negedge clk);
    while ((four ? busy4 : busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(four ? "idle4" : "idle", 32'(four ? busy4 : busy), 32'd0);
  endtask

  // Slave model: decides hready/hresp for the current cycle at the negedge and logs
  // the write that completes at the following posedge.
  logic        data_active = 1'b0;
  logic        err_this = 1'b0;
  logic [31:0] d_addr = '0;
  int          a_cnt = 0, d_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      data_active = 1'b0;
      a_cnt = 0;
      d_cnt = 0;
      hready = 1'b0;
      hresp  = 1'b0;
    end else if (data_active) begin
      if (d_cnt < data_wait) begin
        hready = 1'b0;
        hresp  = err_this && (d_cnt == data_wait - 1);
        if (hresp) checkOutput("htrans_err_first", 32'(htrans), 32'd0);
        d_cnt++;
      end else begin
        hready = 1'b1;
        hresp  = err_this;
        if (err_this) checkOutput("htrans_err_last", 32'(htrans), 32'd0);
        log_a.push_back(d_addr);
        log_d.push_back(hwdata);
        log_ok.push_back(!err_this);
        data_active = 1'b0;
        err_this = 1'b0;
        d_cnt = 0;
      end
    end else if (htrans == 2'b10) begin
      hresp = 1'b0;
      if (a_cnt < addr_wait) begin
        hready = 1'b0;
        a_cnt++;
      end else begin
        hready = 1'b1;
        a_cnt = 0;
        data_active = 1'b1;
        d_addr = haddr;
        err_this = err_arm && (haddr == err_addr);
      end
    end else begin
      hready = 1'b1;
      hresp  = 1'b0;
    end
  end

  // Zero-wait monitor for the four-channel instance, sharing the write log.
  logic        p4 = 1'b0;
  logic [31:0] a4 = '0;

  always @(negedge clk) begin
    if (reset4) begin
      p4 = 1'b0;
    end else begin
      if (p4) begin
        log_a.push_back(a4);
        log_d.push_back(hwdata4);
        log_ok.push_back(1'b1);
        p4 = 1'b0;
      end
      if (htrans4 == 2'b10) begin
        p4 = 1'b1;
        a4 = haddr4;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    reset4   = 1'b1;
    ch_data  = {8'h22, 8'h11};
    ch_data4 = {8'h44, 8'h33, 8'h22, 8'h11};
    refresh  = 1'b0;
    refresh4 = 1'b0;

    // Reset state, then the initial refresh batch
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_htrans", 32'(htrans), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_haddr", haddr, 32'd0);
    checkOutput("rst_hwdata", hwdata, 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
    checkOutput("rst_hsize", 32'(hsize), 32'd2);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    reset4 = 1'b0;
    expectWrite(32'hC000_0000, 32'h11, 1'b1);
    expectWrite(32'hC000_0004, 32'h22, 1'b1);
    expectWrite(32'hC000_0040, 32'h01, 1'b1);
    waitIdle(1'b0);
    compareLog();
    checkOutput("init_wr_count", 32'(wr_count), 32'd3);

    // Channel 1 change with three wait states in both phases
    addr_wait = 3;
    data_wait = 3;
    applyStimulus({8'h5A, 8'h11});
    @(negedge clk);
    checkOutput("ws_pre_htrans", 32'(htrans), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ws_addr_htrans%0d", i), 32'(htrans), 32'd2);
      checkOutput($sformatf("ws_addr_haddr%0d", i), haddr, 32'hC000_0004);
      checkOutput($sformatf("ws_addr_hwrite%0d", i), 32'(hwrite), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ws_data_htrans%0d", i), 32'(htrans), 32'd0);
      checkOutput($sformatf("ws_data_hwdata%0d", i), hwdata, 32'h5A);
    end
    expectWrite(32'hC000_0004, 32'h5A, 1'b1);
    expectWrite(32'hC000_0040, 32'h01, 1'b1);
    waitIdle(1'b0);
    compareLog();
    checkOutput("ws_wr_count", 32'(wr_count), 32'd5);

    // Channel 0 toggles twice while a channel 1 write sits in its data phase
    addr_wait = 0;
    data_wait = 2;
    applyStimulus({8'h66, 8'h11});
    applyStimulus({8'h66, 8'h11});
    applyStimulus({8'h66, 8'h12});
    applyStimulus({8'h66, 8'h13});
    expectWrite(32'hC000_0004, 32'h66, 1'b1);
    expectWrite(32'hC000_0000, 32'h13, 1'b1);
    expectWrite(32'hC000_0040, 32'h01, 1'b1);
    waitIdle(1'b0);
    compareLog();
    checkOutput("tog_wr_count", 32'(wr_count), 32'd8);

    // Two-cycle ERROR on the channel 0 write
    data_wait = 1;
    err_arm   = 1'b1;
    applyStimulus({8'h88, 8'h77});
    expectWrite(32'hC000_0000, 32'h77, 1'b0);
    expectWrite(32'hC000_0004, 32'h88, 1'b1);
    expectWrite(32'hC000_0040, 32'h01, 1'b1);
    waitIdle(1'b0);
    compareLog();
    checkOutput("err_flag", 32'(err), 32'd1);
    checkOutput("err_wr_count", 32'(wr_count), 32'd10);
    err_arm   = 1'b0;
    data_wait = 0;

    // Refresh pulse on the four-channel build
    @(posedge clk);
    #1;
    refresh4 = 1'b1;
    @(posedge clk);
    #1;
    refresh4 = 1'b0;
    expectWrite(32'hC000_0000, 32'h11, 1'b1);
    expectWrite(32'hC000_0004, 32'h22, 1'b1);
    expectWrite(32'hC000_0008, 32'h33, 1'b1);
    expectWrite(32'hC000_000C, 32'h44, 1'b1);
    expectWrite(32'hC000_0040, 32'h01, 1'b1);
    waitIdle(1'b1);
    compareLog();
    checkOutput("ref4_wr_count", 32'(wr_count4), 32'd5);
    checkOutput("err_sticky", 32'(err), 32'd1);

    // Reset during a stalled data phase, then the post-reset refresh batch
    data_wait = 10;
    applyStimulus({8'h88, 8'h99});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_pre_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    data_wait = 0;
    @(negedge clk);
    checkOutput("abort_htrans", 32'(htrans), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_wr_count", 32'(wr_count), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    expectWrite(32'hC000_0000, 32'h99, 1'b1);
    expectWrite(32'hC000_0004, 32'h88, 1'b1);
    expectWrite(32'hC000_0040, 32'h01, 1'b1);
    waitIdle(1'b0);
    compareLog();
    checkOutput("post_rst_wr_count", 32'(wr_count), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
